// File: rtl/dmem_wait_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_wait_responder_if
//   Data-memory bus between the MEM pipeline stage (master) and the
//   wait-state memory responder (slave).
//
//   Handshake semantics (the single contract for this bus):
//     - A request is mem_read or mem_write held high by the master together
//       with a stable addr/write_data.
//     - The slave accepts a request in the cycle it is seen while idle and
//       raises stall in that same cycle; the master must hold every request
//       signal unchanged while stall is high.
//     - Completion is signalled by a one-cycle resp_valid pulse (stall low);
//       the request still visible in that cycle is the one just completed and
//       is not accepted again. The master may present a new request in the
//       following cycle.
//     - A misaligned or read+write request is rejected: no stall, no access,
//       one-cycle access_err pulse in the next cycle.
//     - read_data holds the result of the most recent completed load.
//
//   Signals
//     mem_read    master->slave  load request
//     mem_write   master->slave  store request
//     addr        master->slave  byte address (32)
//     write_data  master->slave  store data (32)
//     read_data   slave->master  load result (32)
//     stall       slave->master  access in progress, hold inputs
//     resp_valid  slave->master  completion pulse
//     access_err  slave->master  rejected-request pulse
// ----------------------------------------------------------------------------
interface dmem_wait_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        resp_valid;
    logic        access_err;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, stall, resp_valid, access_err
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, stall, resp_valid, access_err
    );
endinterface

// File: rtl/dmem_wait_responder.sv
// ----------------------------------------------------------------------------
// dmem_wait_responder
//   Memory-side responder for the MEM stage. Each accepted load/store takes
//   WAIT_CYCLES+1 stalled cycles followed by one response cycle. Replaces a
//   single-cycle data memory between EX/MEM and MEM/WB.
//
//   Parameters
//     DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//     WAIT_CYCLES  busy cycles per access (1..15)
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous, active-high
//     bus        dmem_wait_responder_if.slave (request/response bus)
//     state_dbg  current FSM state (0=IDLE, 1=BUSY, 2=RESP)
// ----------------------------------------------------------------------------
module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    dmem_wait_responder_if.slave      bus,
    output logic [1:0]                state_dbg
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        counter;
    logic              lat_write;
    logic [IDX_W-1:0]  lat_idx;
    logic [31:0]       lat_data;
    logic [31:0]       read_data_q;
    logic              resp_valid_q;
    logic              access_err_q;

    // Storage has no reset of its own so it can map onto a RAM; a per-word
    // written flag (cleared by reset) makes every word read back as zero
    // until it has been stored to since the last reset.
    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] word_written;

    logic             req;
    logic             bad;
    logic             accept;
    logic             do_access;
    logic [IDX_W-1:0] req_idx;
    logic             unused_addr_hi;

    assign req     = bus.mem_read | bus.mem_write;
    assign bad     = (bus.addr[1:0] != 2'b00) | (bus.mem_read & bus.mem_write);
    assign accept  = (state == IDLE) & req & ~bad;
    assign req_idx = bus.addr[IDX_W+1:2];

    // Upper address bits wrap silently; they play no part in the access.
    assign unused_addr_hi = ^bus.addr[31:IDX_W+2];

    assign do_access = (state == BUSY) && (counter == 4'd0);

    // Stall rises combinationally in the accepting cycle so the pipeline
    // freezes before the request advances; forced low while in reset.
    assign bus.stall      = ~reset & ((state == BUSY) | accept);
    assign bus.read_data  = read_data_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.access_err = access_err_q;
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= 4'd0;
            lat_write    <= 1'b0;
            lat_idx      <= '0;
            lat_data     <= 32'd0;
            read_data_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            word_written <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= bus.mem_write;
                        lat_idx   <= req_idx;
                        lat_data  <= bus.write_data;
                        counter   <= CNT_INIT;
                        state     <= BUSY;
                    end else if (req) begin
                        // req without accept means a bad request
                        access_err_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        if (lat_write) begin
                            word_written[lat_idx] <= 1'b1;
                        end else begin
                            read_data_q <= word_written[lat_idx] ? mem[lat_idx] : 32'd0;
                        end
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // The request still on the bus is the one just served.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write port; a reset during BUSY suppresses the pending store.
    always_ff @(posedge clk) begin
        if (!reset && do_access && lat_write) begin
            mem[lat_idx] <= lat_data;
        end
    end

endmodule
